// File: rtl/softex_lane_scheduler.sv
// softex_lane_scheduler
// Phase sequencer for the parallel softmax lanes. It takes one job (beat
// count plus lane mask) and walks the active lanes through accumulate, drain,
// serial cross-lane reduction and normalize. It then pulses done for one cycle.
//
// Reducer handshake: red_valid_o and red_sel_o stay constant while REDUCE
// waits. A grant completes in any cycle where red_valid_o && red_ready_i, and
// the next cycle shows the next active lane, or NORM after the last lane.
// red_ready_i has no effect outside REDUCE.
module softex_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16,
  parameter int SEL_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     beats_i,
  input  logic [NUM_LANES-1:0] lane_mask_i,
  input  logic                 in_beat_i,
  input  logic                 out_beat_i,
  input  logic [NUM_LANES-1:0] lane_busy_i,
  input  logic                 red_ready_i,
  output logic [NUM_LANES-1:0] acc_en_o,
  output logic [NUM_LANES-1:0] norm_en_o,
  output logic                 red_valid_o,
  output logic [SEL_W-1:0]     red_sel_o,
  output logic [2:0]           phase_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC    = 3'd1,
    S_DRAIN  = 3'd2,
    S_REDUCE = 3'd3,
    S_NORM   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               state_q, nxt_state;
  logic [CNT_W-1:0]     cnt_q, nxt_cnt;
  logic [CNT_W-1:0]     beats_q, nxt_beats;
  logic [NUM_LANES-1:0] mask_q, nxt_mask;
  logic [SEL_W-1:0]     sel_q, nxt_sel;
  logic [SEL_W:0]       upper;
  logic                 last_beat;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [SEL_W-1:0] lowest_bit(input logic [NUM_LANES-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [SEL_W:0] next_bit(input logic [NUM_LANES-1:0] m,
                                               input logic [SEL_W-1:0]     cur);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

  // beats_q is never 0 in ACC/NORM, so beats_q-1 never underflows there and
  // the counter stops at beats_q-1, which avoids wrap even at the full range.
  assign last_beat = (cnt_q == (beats_q - CNT_W'(1)));
  assign upper     = next_bit(mask_q, sel_q);

  // Next-state, counter and grant-pointer logic.
  always_comb begin
    nxt_state = state_q;
    nxt_cnt   = cnt_q;
    nxt_beats = beats_q;
    nxt_mask  = mask_q;
    nxt_sel   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          nxt_beats = beats_i;
          nxt_mask  = lane_mask_i;
          nxt_cnt   = '0;
          if ((beats_i == '0) || (lane_mask_i == '0)) nxt_state = S_DONE;
          else                                        nxt_state = S_ACC;
        end
      end
      S_ACC: begin
        if (in_beat_i) begin
          if (last_beat) begin
            nxt_cnt   = '0;
            nxt_state = S_DRAIN;
          end else begin
            nxt_cnt = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if ((lane_busy_i & mask_q) == '0) begin
          nxt_sel   = lowest_bit(mask_q);
          nxt_state = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (red_ready_i) begin
          if (upper[SEL_W]) nxt_sel   = upper[SEL_W-1:0];
          else              nxt_state = S_NORM;
        end
      end
      S_NORM: begin
        if (out_beat_i) begin
          if (last_beat) begin
            nxt_cnt   = '0;
            nxt_state = S_DONE;
          end else begin
            nxt_cnt = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // State, job registers and registered Moore outputs; reset/clear win.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      beats_q     <= '0;
      mask_q      <= '0;
      sel_q       <= '0;
      acc_en_o    <= '0;
      norm_en_o   <= '0;
      red_valid_o <= 1'b0;
      red_sel_o   <= '0;
      phase_o     <= 3'd0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state_q     <= nxt_state;
      cnt_q       <= nxt_cnt;
      beats_q     <= nxt_beats;
      mask_q      <= nxt_mask;
      sel_q       <= nxt_sel;
      acc_en_o    <= (nxt_state == S_ACC)  ? nxt_mask : '0;
      norm_en_o   <= (nxt_state == S_NORM) ? nxt_mask : '0;
      red_valid_o <= (nxt_state == S_REDUCE);
      red_sel_o   <= nxt_sel;
      phase_o     <= nxt_state;
      busy_o      <= (nxt_state != S_IDLE);
      done_o      <= (nxt_state == S_DONE);
    end
  end

endmodule

// File: doc/softex_lane_scheduler.md
Name: softex_lane_scheduler

Overview:
- Phase sequencer for the NUM_LANES parallel softmax datapath lanes.
- Takes one job (beat count plus lane mask) and steps the lanes through four phases: accumulate, drain, serial cross-lane reduction, normalize.
- Grants a single shared reduction unit to one lane at a time.
- Sits between the top-level controller (which issues start and reads done) and the lane array / shared reducer.

Parameters:
- NUM_LANES, 4, number of datapath lanes scheduled.
- CNT_W, 16, width of the beat counters and of beats_i.
- SEL_W, $clog2(NUM_LANES) (min 1), width of red_sel_o.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- start_i  in  1  job start pulse; sampled only in IDLE.
- beats_i  in  CNT_W  input beats (= output beats) of the job; sampled with start_i.
- lane_mask_i  in  NUM_LANES  lanes active for the job; sampled with start_i.
- in_beat_i  in  1  one input-stream beat transferred this cycle (valid&ready).
- out_beat_i  in  1  one output-stream beat transferred this cycle (valid&ready).
- lane_busy_i  in  NUM_LANES  per-lane pipeline-not-empty flag.
- red_ready_i  in  1  shared reducer accepted the current lane's partials.
- acc_en_o  out  NUM_LANES  per-lane accumulate enable.
- norm_en_o  out  NUM_LANES  per-lane normalize enable.
- red_valid_o  out  1  reduction request valid.
- red_sel_o  out  SEL_W  lane currently granted the reducer.
- phase_o  out  3  encoded state: IDLE=0, ACC=1, DRAIN=2, REDUCE=3, NORM=4, DONE=5.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
Reset and clear:
- rst_i or clear_i (synchronous, highest priority) forces state IDLE and zeroes the counters, latched mask, latched beats and red_sel.
- All outputs are 0 in the cycle after either is asserted; an in-flight job is abandoned with no done_o.

State and outputs:
- Moore machine with registered state.
- acc_en_o = mask_q when ACC, else 0. norm_en_o = mask_q when NORM, else 0.
- red_valid_o = 1 only in REDUCE. done_o = 1 only in DONE.

Transitions:
- IDLE: on start_i, latch beats_i and lane_mask_i and clear beat_cnt.
  - If beats_i==0 or lane_mask_i==0: go to DONE.
  - Otherwise: go to ACC.
  - Latency from start_i to first acc_en_o is 1 cycle.
- ACC: beat_cnt increments on in_beat_i. When in_beat_i && beat_cnt==beats_q-1, clear beat_cnt and go to DRAIN.
- DRAIN: stay at least 1 cycle. Go to REDUCE in the cycle where (lane_busy_i & mask_q)==0. On entry, red_sel is loaded with the lowest set bit of mask_q.
- REDUCE: valid/ready handshake.
  - red_valid_o and red_sel_o are held stable until red_ready_i.
  - On red_ready_i, red_sel advances to the next higher set bit of mask_q, skipping masked-off lanes.
  - If the current lane is the highest set bit, go to NORM instead.
  - Each active lane is granted exactly once, in ascending index order.
- NORM: beat_cnt counts out_beat_i. On out_beat_i && beat_cnt==beats_q-1, go to DONE.
- DONE: done_o=1 for exactly 1 cycle, then IDLE.

Boundary rules:
- start_i outside IDLE (including the DONE cycle) is ignored; input changes in busy states are ignored.
- in_beat_i outside ACC and out_beat_i outside NORM are ignored and do not change counters.
- beats_i = 2^CNT_W-1 must complete without counter overflow; beat_cnt never wraps within a job.
- A single-lane mask makes REDUCE one handshake long.
- red_ready_i may be held high continuously, giving one lane per cycle.
- red_sel_o holds its last value outside REDUCE and is 0 after reset.

Test Plan:
- Reset mid-job: start beats=4 mask=4'b1111, assert rst_i during ACC after 2 beats -> next cycle phase_o=0, busy_o=0, acc_en_o=0; no done_o; a new start then runs normally.
- Nominal job: start beats=3 mask=4'b1111, 3 in_beats (with gaps), lane_busy held 2 cycles, red_ready_i always 1, 3 out_beats -> red_sel_o sequence 0,1,2,3 on consecutive cycles; done_o single pulse; busy_o high from start+1 through the DONE cycle.
- Sparse mask: mask=4'b1010, red_ready_i asserted every 3rd cycle -> red_sel_o=1 then 3, each held stable until ready; acc_en_o=norm_en_o=4'b1010.
- Degenerate: beats=0 with mask=4'b1111, or mask=0 with beats=5 -> DONE one cycle after start, done_o pulse, no enables ever asserted.
- Ignored events: start_i during NORM, in_beat_i during NORM, out_beat_i during ACC -> counters and phase unaffected; job completes after exactly beats_q qualifying beats per phase.
- Max count: CNT_W=4, beats=15 -> exactly 15 in_beats end ACC and 15 out_beats end NORM; no early exit or wrap.
